// File: rtl/wide_crc_pkg.sv
// Shared types and feedback tap positions for the wide CRC sequencer.
package wide_crc_pkg;

    typedef enum logic [1:0] {
        OpNop  = 2'd0,
        OpLoad = 2'd1,
        OpRun  = 2'd2,
        OpDump = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDump = 2'd2
    } state_e;

    localparam int unsigned TAP_A = 63;
    localparam int unsigned TAP_B = 2;
    localparam int unsigned TAP_C = 0;

endpackage

// File: rtl/wide_crc_sequencer_if.sv
// Command, dump-stream and status signals between host/sink and the sequencer.
interface wide_crc_sequencer_if #(
    parameter int unsigned WORD = 32
) ();

    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_op;
    logic [WORD-1:0] cmd_data;
    logic            out_valid;
    logic            out_ready;
    logic [WORD-1:0] out_data;
    logic            out_last;
    logic            busy;
    logic            done;

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, out_ready,
        output cmd_ready, out_valid, out_data, out_last, busy, done
    );

    modport master (
        output cmd_valid, cmd_op, cmd_data, out_ready,
        input  cmd_ready, out_valid, out_data, out_last, busy, done
    );

endinterface

// File: rtl/wide_crc_reg.sv
// W-bit feedback shift register with word-wise load and single-step feedback.
module wide_crc_reg
    import wide_crc_pkg::*;
#(
    parameter int unsigned W    = 4096,
    parameter int unsigned WORD = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_en_i,
    input  logic [WORD-1:0] load_word_i,
    input  logic            step_en_i,
    output logic [W-1:0]    crc_o
);

    logic [W-1:0] crc_q, crc_d;
    logic         feedback;

    assign feedback = crc_q[TAP_A] ^ crc_q[TAP_B] ^ crc_q[TAP_C];

    // Load and step are mutually exclusive by construction (load only in idle).
    always_comb begin
        crc_d = crc_q;
        if (load_en_i) begin
            crc_d = {crc_q[W-WORD-1:0], load_word_i};
        end else if (step_en_i) begin
            crc_d = {crc_q[W-2:0], feedback};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/wide_crc_sequencer.sv
// Command sequencer: loads, steps and streams out a wide CRC register word by word.
module wide_crc_sequencer
    import wide_crc_pkg::*;
#(
    parameter int unsigned W     = 4096,
    parameter int unsigned WORD  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    wide_crc_sequencer_if.slave  bus
);

    localparam int unsigned NWORDS = W / WORD;
    localparam int unsigned IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             done_q, done_d;

    op_e              op;
    logic             cmd_fire;
    logic             out_fire;
    logic             load_en;
    logic             step_en;
    logic [CNT_W-1:0] run_len;
    logic [W-1:0]     crc;
    logic [WORD-1:0]  words [NWORDS];

    assign op       = op_e'(bus.cmd_op);
    assign run_len  = bus.cmd_data[CNT_W-1:0];
    assign cmd_fire = bus.cmd_valid && (state_q == StIdle);
    assign out_fire = (state_q == StDump) && bus.out_ready;
    assign load_en  = cmd_fire && (op == OpLoad);
    assign step_en  = (state_q == StRun);

    wide_crc_reg #(
        .W    (W),
        .WORD (WORD)
    ) u_reg (
        .clk         (clk),
        .reset       (reset),
        .load_en_i   (load_en),
        .load_word_i (bus.cmd_data),
        .step_en_i   (step_en),
        .crc_o       (crc)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd_fire) begin
                    unique case (op)
                        OpRun: begin
                            if (run_len == '0) begin
                                done_d = 1'b1;
                            end else begin
                                state_d = StRun;
                                cnt_d   = run_len;
                            end
                        end
                        OpDump: begin
                            state_d = StDump;
                            idx_d   = '0;
                        end
                        default: ;
                    endcase
                end
            end
            StRun: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            StDump: begin
                if (out_fire) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = StIdle;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    // Word 0 is the most-significant slice of the register.
    for (genvar i = 0; i < NWORDS; i++) begin : g_words
        assign words[i] = crc[W-1-i*WORD -: WORD];
    end

    assign bus.cmd_ready = (state_q == StIdle);
    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = done_q;
    assign bus.out_valid = (state_q == StDump);
    assign bus.out_last  = (state_q == StDump) && (idx_q == LAST_IDX);
    assign bus.out_data  = (state_q == StDump) ? words[idx_q] : '0;

endmodule

// File: tb/tb_wide_crc_sequencer.sv
// Self-checking bench: random loads/runs/dumps against a bit-vector model of the register.
module tb_wide_crc_sequencer;
    import wide_crc_pkg::*;

    localparam int unsigned W     = 4096;
    localparam int unsigned WORD  = 32;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned NW    = W / WORD;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wide_crc_sequencer_if #(.WORD(WORD)) bus ();

    wide_crc_sequencer #(
        .W     (W),
        .WORD  (WORD),
        .CNT_W (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int unsigned  n_checks = 0;
    int unsigned  n_fails  = 0;
    logic [W-1:0] model;

    function automatic logic [WORD-1:0] model_word(input int i);
        return model[W-1-i*WORD -: WORD];
    endfunction

    task automatic model_load(input logic [WORD-1:0] w);
        model = (model << WORD) | W'(w);
    endtask

    task automatic model_step(input int n);
        logic fb;
        for (int k = 0; k < n; k++) begin
            fb    = model[63] ^ model[2] ^ model[0];
            model = (model << 1) | W'(fb);
        end
    endtask

    // Called and returns at a negedge; command accepted at the posedge in between.
    task automatic issue(input op_e op, input logic [WORD-1:0] data);
        int guard;
        guard        = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        while (!bus.cmd_ready && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.cmd_ready) begin
            n_checks++;
            n_fails++;
            $display("FAIL cmd_accept: cmd_ready=%b after %0d cycles, required 1", bus.cmd_ready,
                     guard);
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OpNop;
        bus.cmd_data  = '0;
    endtask

    task automatic load_word(input logic [WORD-1:0] w);
        issue(OpLoad, w);
        model_load(w);
    endtask

    task automatic run_steps(input int n);
        int cyc;
        int busy_cyc;
        issue(OpRun, WORD'(n));
        cyc      = 0;
        busy_cyc = 0;
        while (!bus.done && cyc < n + 5) begin
            if (bus.busy) busy_cyc++;
            @(negedge clk);
            cyc++;
        end
        model_step(n);
        n_checks++;
        if (bus.done !== 1'b1 || cyc != n) begin
            n_fails++;
            $display("FAIL run_done_time: done=%b at cycle %0d, required 1 at cycle %0d", bus.done,
                     cyc, n);
        end
        n_checks++;
        if (busy_cyc != n || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL run_busy: busy cycles=%0d busy=%b ready=%b, required %0d/0/1", busy_cyc,
                     bus.busy, bus.cmd_ready, n);
        end
        @(negedge clk);
        n_checks++;
        if (bus.done !== 1'b0) begin
            n_fails++;
            $display("FAIL run_done_pulse: done=%b one cycle later, required 0", bus.done);
        end
    endtask

    task automatic dump_check(input int stall_at, input int stall_len, input bit rand_bp,
                              input bit hold_cmd);
        int  stalls;
        int  guard;
        bit  accepted;
        issue(OpDump, '0);
        if (hold_cmd) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_op    = OpNop;
        end
        for (int i = 0; i < int'(NW); i++) begin
            stalls   = (i == stall_at) ? stall_len : 0;
            guard    = 0;
            accepted = 1'b0;
            while (!accepted && guard < 64) begin
                n_checks++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== model_word(i)
                    || bus.out_last !== (i == int'(NW) - 1)) begin
                    n_fails++;
                    $display("FAIL dump_word[%0d]: valid=%b data=%h last=%b, required 1/%h/%b", i,
                             bus.out_valid, bus.out_data, bus.out_last, model_word(i),
                             i == int'(NW) - 1);
                end
                if (hold_cmd) begin
                    n_checks++;
                    if (bus.cmd_ready !== 1'b0) begin
                        n_fails++;
                        $display("FAIL dump_cmd_ready[%0d]: cmd_ready=%b, required 0", i,
                                 bus.cmd_ready);
                    end
                end
                if (stalls > 0) begin
                    bus.out_ready = 1'b0;
                    stalls--;
                end else begin
                    bus.out_ready = rand_bp ? ($urandom_range(0, 2) != 0) : 1'b1;
                end
                accepted = bus.out_ready;
                @(negedge clk);
                guard++;
            end
        end
        bus.out_ready = 1'b0;
        bus.cmd_valid = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            n_fails++;
            $display("FAIL dump_end: valid=%b done=%b busy=%b, required 0/1/0", bus.out_valid,
                     bus.done, bus.busy);
        end
        @(negedge clk);
        n_checks++;
        if (bus.done !== 1'b0) begin
            n_fails++;
            $display("FAIL dump_done_pulse: done=%b, required 0", bus.done);
        end
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OpNop;
        bus.cmd_data  = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model = '0;
        n_checks++;
        if (bus.cmd_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_last !== 1'b0
            || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.out_data !== '0) begin
            n_fails++;
            $display("FAIL reset_state: ready=%b valid=%b last=%b busy=%b done=%b data=%h, required 1/0/0/0/0/0",
                     bus.cmd_ready, bus.out_valid, bus.out_last, bus.busy, bus.done, bus.out_data);
        end
        @(negedge clk);
    endtask

    task automatic test_load_dump();
        for (int i = 0; i < int'(NW); i++) load_word(WORD'(i));
        dump_check(-1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_single_tap();
        for (int i = 0; i < int'(NW); i++) load_word((i == 126) ? 32'h8000_0000 : 32'h0);
        run_steps(1);
        dump_check(-1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_run_zero();
        run_steps(0);
        dump_check(-1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < int'(NW); i++) load_word($urandom);
        dump_check(5, 3, 1'b0, 1'b1);
        dump_check(-1, 0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        issue(OpRun, WORD'(1000));
        repeat (399) @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fails++;
            $display("FAIL mid_run_busy: busy=%b, required 1", bus.busy);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model = '0;
        n_checks++;
        if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fails++;
            $display("FAIL abort_state: ready=%b busy=%b done=%b, required 1/0/0", bus.cmd_ready,
                     bus.busy, bus.done);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus.done !== 1'b0) begin
                n_fails++;
                $display("FAIL abort_no_done[%0d]: done=%b, required 0", k, bus.done);
            end
        end
        dump_check(-1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_random_seed();
        for (int i = 0; i < int'(NW); i++) load_word($urandom);
        run_steps(1);
        dump_check(-1, 0, 1'b1, 1'b0);
        run_steps(int'($urandom_range(2, 300)));
        dump_check(-1, 0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) load_word($urandom);
            run_steps(int'($urandom_range(0, 70)));
            dump_check(-1, 0, 1'b1, 1'b0);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OpNop;
        bus.cmd_data  = '0;
        bus.out_ready = 1'b0;
        model         = '0;
        @(negedge clk);
        test_reset();
        test_load_dump();
        test_single_tap();
        test_run_zero();
        test_backpressure();
        test_reset_mid_run();
        test_random_seed();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
